dcache_nway: RTL



---
 rtl/dcache_nway_if.sv | 27 ++
 rtl/dcache_nway.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway_if.sv
// Signal bundle for dcache_nway: datapath data port plus memory/bus-controller data port.
interface dcache_nway_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement
// and an end-of-run flush that writes the hits-minus-misses statistic to STAT_ADDR.
module dcache_nway #(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned SETS        = 8,
    parameter int unsigned BLOCK_WORDS = 2,
    parameter logic [31:0] STAT_ADDR   = 32'h0000_3100
) (
    input logic          CLK,
    input logic          RST,
    dcache_nway_if.slave bus
);
    localparam int unsigned WOB = $clog2(BLOCK_WORDS);
    localparam int unsigned SB  = $clog2(SETS);
    localparam int unsigned AB  = $clog2(WAYS);
    localparam int unsigned WIW = (WOB > 0) ? WOB : 1;
    localparam int unsigned TB  = 30 - WOB - SB;

    typedef enum logic [2:0] {StIdle, StWb, StLd, StFscan, StFwb, StStat, StHalted} state_e;

    state_e          state_q, state_d;
    logic            valid_q [SETS][WAYS];
    logic            dirty_q [SETS][WAYS];
    logic [TB-1:0]   tag_q   [SETS][WAYS];
    logic [AB-1:0]   age_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][BLOCK_WORDS];
    logic [WIW-1:0]  wcnt_q;
    logic [AB-1:0]   victim_q;
    logic [SB-1:0]   scan_set_q;
    logic [AB-1:0]   scan_way_q;
    logic [31:0]     stat_q;
    logic            replay_q;

    logic [29:0]     waddr;
    logic [WIW-1:0]  a_word;
    logic [SB-1:0]   a_set;
    logic [TB-1:0]   a_tag;
    logic            access, hit, miss, hit_now, found;
    logic [AB-1:0]   hit_way, vict;
    logic            last_word, last_line, xfer, scan_adv;

    assign waddr  = bus.dmemaddr[31:2];
    assign a_word = WIW'(waddr & 30'(BLOCK_WORDS - 1));
    assign a_set  = SB'(waddr >> WOB);
    assign a_tag  = TB'(waddr >> (WOB + SB));
    assign access = bus.dmemREN | bus.dmemWEN;

    function automatic logic [31:0] mem_addr(input logic [TB-1:0] t, input logic [SB-1:0] s,
                                             input logic [WIW-1:0] w);
        logic [31:0] a;
        a = 32'(t);
        a = (a << SB) | 32'(s);
        a = (a << WOB) | (32'(w) & (BLOCK_WORDS - 1));
        return a << 2;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vict    = '0;
        found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[a_set][w] && tag_q[a_set][w] == a_tag) begin
                hit     = 1'b1;
                hit_way = AB'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[a_set][w]) begin
                vict  = AB'(w);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[a_set][w] == AB'(WAYS - 1)) vict = AB'(w);
            end
        end
    end

    assign miss    = (state_q == StIdle) && access && !hit;
    assign hit_now = (state_q == StIdle) && access && hit;

    always_comb begin
        state_d      = state_q;
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        xfer         = 1'b0;
        scan_adv     = 1'b0;
        last_word    = (wcnt_q == WIW'(BLOCK_WORDS - 1));
        last_line    = (scan_set_q == SB'(SETS - 1)) && (scan_way_q == AB'(WAYS - 1));
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    state_d = (valid_q[a_set][vict] && dirty_q[a_set][vict]) ? StWb : StLd;
                end else begin
                    if (hit_now) begin
                        bus.dhit     = 1'b1;
                        bus.dmemload = data_q[a_set][hit_way][a_word];
                    end
                    if (bus.halt) state_d = StFscan;
                end
            end
            StWb: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = mem_addr(tag_q[a_set][victim_q], a_set, wcnt_q);
                bus.dstore = data_q[a_set][victim_q][wcnt_q];
                xfer       = !bus.dwait;
                if (xfer && last_word) state_d = StLd;
            end
            StLd: begin
                bus.dREN  = 1'b1;
                bus.daddr = mem_addr(a_tag, a_set, wcnt_q);
                xfer      = !bus.dwait;
                if (xfer && last_word) state_d = StIdle;
            end
            StFscan: begin
                if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) begin
                    state_d = StFwb;
                end else begin
                    scan_adv = 1'b1;
                    if (last_line) state_d = StStat;
                end
            end
            StFwb: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = mem_addr(tag_q[scan_set_q][scan_way_q], scan_set_q, wcnt_q);
                bus.dstore = data_q[scan_set_q][scan_way_q][wcnt_q];
                xfer       = !bus.dwait;
                // A dirty final line finishes the scan here rather than rescanning from set 0.
                if (xfer && last_word) begin
                    scan_adv = 1'b1;
                    state_d  = last_line ? StStat : StFscan;
                end
            end
            StStat: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = STAT_ADDR;
                bus.dstore = stat_q;
                if (!bus.dwait) state_d = StHalted;
            end
            StHalted: bus.flushed = 1'b1;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            victim_q   <= '0;
            scan_set_q <= '0;
            scan_way_q <= '0;
            stat_q     <= '0;
            replay_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss) victim_q <= vict;
            if (xfer) wcnt_q <= last_word ? '0 : wcnt_q + 1'b1;
            if (scan_adv) begin
                if (scan_way_q == AB'(WAYS - 1)) begin
                    scan_way_q <= '0;
                    scan_set_q <= scan_set_q + 1'b1;
                end else begin
                    scan_way_q <= scan_way_q + 1'b1;
                end
            end
            // The hit that replays a refilled access was already counted as its miss.
            if (hit_now) begin
                if (replay_q) replay_q <= 1'b0;
                else          stat_q   <= stat_q + 32'd1;
            end else if (miss) begin
                stat_q <= stat_q - 32'd1;
            end
            if (state_q == StLd && xfer && last_word) replay_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= AB'(w);
                    for (int b = 0; b < BLOCK_WORDS; b++) data_q[s][w][b] <= '0;
                end
            end
        end else begin
            if (hit_now) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AB'(w) == hit_way)                          age_q[a_set][w] <= '0;
                    else if (age_q[a_set][w] < age_q[a_set][hit_way]) age_q[a_set][w] <= age_q[a_set][w] + 1'b1;
                end
                if (bus.dmemWEN) begin
                    data_q[a_set][hit_way][a_word] <= bus.dmemstore;
                    dirty_q[a_set][hit_way]        <= 1'b1;
                end
            end
            if (state_q == StLd && xfer) begin
                data_q[a_set][victim_q][wcnt_q] <= bus.dload;
                if (last_word) begin
                    valid_q[a_set][victim_q] <= 1'b1;
                    dirty_q[a_set][victim_q] <= 1'b0;
                    tag_q[a_set][victim_q]   <= a_tag;
                end
            end
            if (state_q == StFwb && xfer && last_word) dirty_q[scan_set_q][scan_way_q] <= 1'b0;
        end
    end
endmodule
